// File: rtl/dmem_wbuf_if.sv
// rtl/dmem_wbuf_if.sv - core load/store bus between the single-cycle core and dmem_wbuf
interface dmem_wbuf_if #(
   parameter int WORD = 32
);
   logic [WORD-1:0] addr;
   logic [WORD-1:0] writeData;
   logic            memWrite;
   logic [WORD-1:0] readData;
   logic            memStall;
   logic            wbEmpty;

   modport master (
      output addr, writeData, memWrite,
      input  readData, memStall, wbEmpty
   );

   modport slave (
      input  addr, writeData, memWrite,
      output readData, memStall, wbEmpty
   );
endinterface

// File: rtl/dmem_wbuf.sv
// rtl/dmem_wbuf.sv - data memory with posted write buffer, load forwarding and store back-pressure
module dmem_wbuf #(
   parameter int WORD      = 32,
   parameter int MEM_WORDS = 256,
   parameter int WB_DEPTH  = 4,
   parameter int WR_LAT    = 4
) (
   input logic        clk,
   input logic        rst_n,
   dmem_wbuf_if.slave bus
);

   localparam int IW   = $clog2(MEM_WORDS);
   localparam int PW   = $clog2(WB_DEPTH);
   localparam int CNTW = PW + 1;
   localparam int CW   = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
   localparam logic [CW-1:0]   LAT_LOAD = CW'(WR_LAT - 1);
   localparam logic [CNTW-1:0] CNT_FULL = CNTW'(WB_DEPTH);

   typedef enum logic {IDLE, BUSY} state_t;

   // word array; never reset so earlier commits survive a reset
   logic [WORD-1:0] mem [MEM_WORDS];

   // write buffer storage, ring indexed by head (oldest) and tail (next free)
   logic [IW-1:0]   wb_idx  [WB_DEPTH];
   logic [WORD-1:0] wb_data [WB_DEPTH];
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [CNTW-1:0] count;
   logic [CNTW-1:0] count_nx;

   state_t          state;
   state_t          state_nx;
   logic [CW-1:0]   lat;
   logic [CW-1:0]   lat_nx;

   logic [IW-1:0]   idx;
   logic            full;
   logic            pop;
   logic            push;
   logic [WORD-1:0] rd_val;
   logic [PW-1:0]   slot;
   logic            addr_unused;

   // byte-offset and high address bits are ignored, so addresses alias onto the array
   assign idx         = bus.addr[IW+1:2];
   assign addr_unused = ^{bus.addr[WORD-1:IW+2], bus.addr[1:0]};

   // the head entry is written to the array on the last cycle of its write window
   assign pop  = (state == BUSY) && (lat == '0);
   assign full = (count == CNT_FULL);
   // a full buffer still takes a store in the cycle its head retires
   assign push = bus.memWrite && (!full || pop);
   assign count_nx = count + CNTW'(push) - CNTW'(pop);

   assign bus.memStall = bus.memWrite && full && !pop;
   assign bus.wbEmpty  = (count == '0) && (state == IDLE);
   assign bus.readData = rd_val;

   // load forwarding: scan oldest to youngest so the youngest matching entry wins
   always_comb begin
      rd_val = mem[idx];
      slot   = head;
      for (int k = 0; k < WB_DEPTH; k++) begin
         slot = head + PW'(k);
         if ((k < int'(count)) && (wb_idx[slot] == idx)) begin
            rd_val = wb_data[slot];
         end
      end
   end

   // capture an accepted store into the tail slot
   always_ff @(posedge clk) begin
      if (push) begin
         wb_idx[tail]  <= idx;
         wb_data[tail] <= bus.writeData;
      end
   end

   // ring pointers and occupancy; reset discards every uncommitted store
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            tail <= tail + PW'(1);
         end
         if (pop) begin
            head <= head + PW'(1);
         end
         count <= count_nx;
      end
   end

   // drain FSM state and write-latency counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         lat   <= '0;
      end else begin
         state <= state_nx;
         lat   <= lat_nx;
      end
   end

   // drain FSM next state: start as soon as an entry is present, chain commits with no idle gap
   always_comb begin
      state_nx = state;
      lat_nx   = lat;
      case (state)
         IDLE: begin
            if (count_nx != '0) begin
               state_nx = BUSY;
               lat_nx   = LAT_LOAD;
            end
         end
         BUSY: begin
            if (lat != '0) begin
               lat_nx = lat - CW'(1);
            end else if (count_nx != '0) begin
               lat_nx = LAT_LOAD;
            end else begin
               state_nx = IDLE;
               lat_nx   = '0;
            end
         end
         default: begin
            state_nx = IDLE;
            lat_nx   = '0;
         end
      endcase
   end

   // commit the head entry to the array on its pop cycle
   always_ff @(posedge clk) begin
      if (pop) begin
         mem[wb_idx[head]] <= wb_data[head];
      end
   end

endmodule

// File: tb/tb_dmem_wbuf.sv
// tb/tb_dmem_wbuf.sv - self-checking bench for dmem_wbuf against a queue-based reference model
module tb_dmem_wbuf;
   localparam int WORD      = 32;
   localparam int MEM_WORDS = 256;
   localparam int WB_DEPTH  = 4;
   localparam int WR_LAT    = 4;

   typedef struct {
      int unsigned idx;
      logic [31:0] data;
      longint      ct;
   } ent_t;

   logic clk;
   logic rst_n;

   dmem_wbuf_if #(.WORD(WORD)) bus ();

   dmem_wbuf #(
      .WORD(WORD), .MEM_WORDS(MEM_WORDS), .WB_DEPTH(WB_DEPTH), .WR_LAT(WR_LAT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int          nerr = 0;
   int          nchk = 0;
   longint      cyc = 0;
   longint      last_ct = -100;
   logic [31:0] mem_m [MEM_WORDS];
   bit          known [MEM_WORDS];
   ent_t        q [$];
   logic [31:0] o_rd;
   logic        o_stall;
   logic        o_empty;
   logic        e_stall;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int unsigned idx_of(input logic [31:0] a);
      return int'((a >> 2) % MEM_WORDS);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s cyc=%0d observed=0x%08h expected=0x%08h", tag, cyc, obs, exp);
      end
   endtask

   // one core cycle: drive at posedge+1, check at negedge, advance the model, wait for the edge
   task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic we);
      int unsigned ix;
      logic [31:0] erd;
      bit          ek;
      bit          pop;
      longint      ct;
      bus.addr      = a;
      bus.writeData = d;
      bus.memWrite  = we;
      #4;
      o_rd    = bus.readData;
      o_stall = bus.memStall;
      o_empty = bus.wbEmpty;
      ix  = idx_of(a);
      ek  = known[ix];
      erd = mem_m[ix];
      foreach (q[k]) begin
         if (q[k].idx == ix) begin
            erd = q[k].data;
            ek  = 1'b1;
         end
      end
      pop     = (q.size() > 0) && (q[0].ct == cyc);
      e_stall = we && (q.size() == WB_DEPTH) && !pop;
      if (ek) chk("readData", o_rd, erd);
      chk("memStall", {31'b0, o_stall}, {31'b0, e_stall});
      chk("wbEmpty", {31'b0, o_empty}, {31'b0, q.size() == 0});
      if (pop) begin
         mem_m[q[0].idx] = q[0].data;
         known[q[0].idx] = 1'b1;
         void'(q.pop_front());
      end
      if (we && !e_stall) begin
         ct = (cyc + WR_LAT > last_ct + WR_LAT) ? cyc + WR_LAT : last_ct + WR_LAT;
         q.push_back('{idx: ix, data: d, ct: ct});
         last_ct = ct;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // present a store and hold it while the model expects a stall
   task automatic store(input logic [31:0] a, input logic [31:0] d, output longint acc);
      int n = 0;
      do begin
         acc = cyc;
         cycle(a, d, 1'b1);
         n++;
      end while (e_stall && n < 64);
      nchk++;
      assert (!e_stall) else begin
         nerr++;
         $error("FAIL store_timeout addr=0x%08h observed=stalled expected=accepted", a);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 100) begin
         cycle(32'h0, 32'h0, 1'b0);
         n++;
      end
      cycle(32'h0, 32'h0, 1'b0);
   endtask

   // async reset asserted between edges; checks the immediate effect, then releases
   task automatic async_reset(input logic [31:0] a);
      bus.addr     = a;
      bus.memWrite = 1'b0;
      rst_n        = 1'b0;
      #1;
      q.delete();
      last_ct = -100;
      chk("rst_wbEmpty", {31'b0, bus.wbEmpty}, 32'h1);
      chk("rst_memStall", {31'b0, bus.memStall}, 32'h0);
      if (known[idx_of(a)]) chk("rst_readData", bus.readData, mem_m[idx_of(a)]);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc++;
   endtask

   initial begin
      longint      acc;
      longint      base;
      longint      accs [6];
      logic [31:0] dv [6];
      logic [31:0] old [3];
      logic [31:0] a;
      logic [31:0] pre18;

      rst_n         = 1'b0;
      bus.addr      = '0;
      bus.writeData = '0;
      bus.memWrite  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_wbEmpty", {31'b0, bus.wbEmpty}, 32'h1);
      chk("reset_memStall", {31'b0, bus.memStall}, 32'h0);
      rst_n = 1'b1;

      // preload every array word through the store path
      for (int i = 0; i < MEM_WORDS; i++) begin
         store(i << 2, (i == 4) ? 32'h12345678 : $urandom, acc);
      end
      drain();

      // test 1: fresh reset, preloaded word visible
      async_reset(32'h10);
      cycle(32'h10, 32'h0, 1'b0);
      chk("t1_readData", o_rd, 32'h12345678);
      chk("t1_wbEmpty", {31'b0, o_empty}, 32'h1);
      chk("t1_memStall", {31'b0, o_stall}, 32'h0);

      // test 2: forwarding then commit at end of relative cycle 4
      cycle(32'h20, 32'hDEADBEEF, 1'b1);
      cycle(32'h20, 32'h0, 1'b0);
      chk("t2_forward", o_rd, 32'hDEADBEEF);
      cycle(32'h20, 32'h0, 1'b0);
      cycle(32'h20, 32'h0, 1'b0);
      cycle(32'h20, 32'h0, 1'b0);
      chk("t2_busy_c4", {31'b0, o_empty}, 32'h0);
      cycle(32'h20, 32'h0, 1'b0);
      chk("t2_empty_c5", {31'b0, o_empty}, 32'h1);
      chk("t2_array", o_rd, 32'hDEADBEEF);

      // test 3: youngest of two same-address stores wins
      store(32'h40, 32'h1, acc);
      store(32'h40, 32'h2, acc);
      cycle(32'h40, 32'h0, 1'b0);
      chk("t3_youngest", o_rd, 32'h2);
      drain();
      cycle(32'h40, 32'h0, 1'b0);
      chk("t3_array", o_rd, 32'h2);

      // test 4: six stores against a four-entry buffer
      base = cyc;
      for (int k = 0; k < 6; k++) begin
         dv[k] = $urandom;
         store(32'h80 + 32'(k * 4), dv[k], acc);
         accs[k] = acc - base;
      end
      chk("t4_acc0", 32'(accs[0]), 32'd0);
      chk("t4_acc3", 32'(accs[3]), 32'd3);
      chk("t4_acc4", 32'(accs[4]), 32'd4);
      chk("t4_acc5", 32'(accs[5]), 32'd8);
      while (cyc - base < 26) begin
         cycle(32'h0, 32'h0, 1'b0);
         if (cyc - base == 25) chk("t4_busy_c24", {31'b0, o_empty}, 32'h0);
         if (cyc - base == 26) chk("t4_empty_c25", {31'b0, o_empty}, 32'h1);
      end
      for (int k = 0; k < 6; k++) begin
         cycle(32'h80 + 32'(k * 4), 32'h0, 1'b0);
         chk("t4_commit", o_rd, dv[k]);
      end

      // test 5: forwarding by index only, aliasing, no same-cycle forward
      store(32'h40, 32'hA, acc);
      store(32'h44, 32'hB, acc);
      cycle(32'h40, 32'h0, 1'b0);
      chk("t5_fwd", o_rd, 32'hA);
      cycle(32'h440, 32'h0, 1'b0);
      chk("t5_alias", o_rd, 32'hA);
      pre18 = mem_m[18];
      cycle(32'h48, 32'hC, 1'b1);
      chk("t5_no_same_cycle_fwd", o_rd, pre18);
      drain();

      // test 6: reset in the middle of a commit with three entries queued
      for (int k = 0; k < 3; k++) old[k] = mem_m[24 + k];
      for (int k = 0; k < 3; k++) store(32'h60 + 32'(k * 4), ~old[k], acc);
      async_reset(32'h60);
      for (int k = 0; k < 3; k++) begin
         cycle(32'h60 + 32'(k * 4), 32'h0, 1'b0);
         chk("t6_old", o_rd, old[k]);
      end
      repeat (WR_LAT + 2) cycle(32'h60, 32'h0, 1'b0);
      chk("t6_still_old", o_rd, old[0]);

      // random traffic focused on a few indices, with aliasing upper bits
      for (int i = 0; i < 400; i++) begin
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[9:2] = 8'($urandom_range(0, 7));
         cycle(a, $urandom, 1'($urandom_range(0, 1)));
      end
      drain();
      for (int i = 0; i < MEM_WORDS; i++) begin
         a = ($urandom & ~32'h3FC) | 32'(i << 2);
         cycle(a, 32'h0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
